alu_pipe: RTL and testbench
===========================

// Module: alu_pipe
// PURPOSE
//  Two-stage pipelined, parametrised ALU; successor to the single-cycle ADD/INC ALU.
//  - Eight operations and Z/C flags in addition to P.
//  - Valid/ready handshake on both sides, with a tag carried alongside each operation.
//  - Sits between the decode stage and writeback; the tag identifies the destination.
// PARAMETERS
//  DATAW  16  operand/result width, >= 4, power of two
//  TAGW    4  width of the pass-through tag
// PORTS
//  clk        in   1       clock; all state updates on rising edge
//  rst        in   1       synchronous, active-high reset
//  in_valid   in   1       operation presented on a/b/alu_op/in_tag
//  in_ready   out  1       block accepts the operation this cycle
//  a          in   DATAW   operand A (unsigned)
//  b          in   DATAW   operand B (unsigned)
//  alu_op     in   3       operation select, see BEHAVIOUR
//  in_tag     in   TAGW    tag, returned unchanged with the result
//  out_valid  out  1       result/flags/out_tag valid
//  out_ready  in   1       consumer takes the result this cycle
//  alu_out    out  DATAW   result
//  p_flag     out  1       predicate flag
//  z_flag     out  1       alu_out == 0
//  c_flag     out  1       carry (ADD/INC) or borrow (SUB); 0 for all other ops
//  out_tag    out  TAGW    tag of the result
//  busy       out  1       either stage holds a valid entry
// BEHAVIOUR
//  Handshakes
//  - Accept on in_valid && in_ready; deliver on out_valid && out_ready.
//  Pipeline
//  - S1 latches a, b, op and tag. S2 holds the computed result, flags and tag.
//  - Latency: accepted in cycle N -> out_valid in cycle N+2 when there is no stall.
//  - Throughput: 1 operation/cycle while out_ready is held high.
//  - S2 loads when !s2_valid || out_ready. S1 advances exactly when S2 loads.
//  - in_ready = !s1_valid || s1_advance. This is combinational from out_ready; no bubble on drain.
//  - Stall: while out_valid && !out_ready, every S2 output holds stable.
//  Operations (results are DATAW bits, unsigned arithmetic)
//  - 000 ADD: a+b; p = (alu_out != 0); c = carry out.
//  - 001 INC: a+1; p = (a > b); c = carry out (a == all ones).
//  - 010 SUB: a-b; p = (a > b); c = borrow (a < b).
//  - 011 AND: a&b; p = (alu_out != 0).
//  - 100 OR:  a|b; p = (alu_out != 0).
//  - 101 XOR: a^b; p = (alu_out != 0).
//  - 110 SHL: a << b[$clog2(DATAW)-1:0]; p = (alu_out != 0).
//  - 111 PASSB: b; p = (alu_out != 0).
//  - z_flag is always (alu_out == 0) and is computed after any saturation.
//  Reset
//  - s1_valid, s2_valid, out_valid, busy = 0.
//  - alu_out, out_tag and all flags = 0.
//  - in_ready = 1 from the first cycle after reset.
//  - Reset mid-operation discards both stages; in-flight operations are never delivered.
//  - in_valid is ignored during the reset cycle.
//  Boundary conditions
//  - Full (both stages valid, out_ready = 0): in_ready = 0; no operation is lost or duplicated.
//  - Simultaneous accept and deliver: both happen in the same cycle and occupancy is unchanged.
//  - Wrap: without saturation, ADD/INC/SUB wrap modulo 2^DATAW.
// CONFIGURATION
//  ALU_PIPE_SAT_EN defined
//  - ADD/INC clamp alu_out to all-ones when carry = 1.
//  - SUB clamps alu_out to 0 when borrow = 1.
//  - c_flag still reports the raw carry/borrow.
//  - p_flag for ADD is evaluated on the clamped result.
//  ALU_PIPE_SAT_EN undefined
//  - Wrapping arithmetic only; no saturation logic is present.
// TESTING (DATAW=8, TAGW=4)
//  1. Reset, then ADD a=3 b=4 tag=5, out_ready=1
//     -> cycle+2: alu_out=7, p=1, z=0, c=0, out_tag=5.
//  2. ADD a=0xFF b=0x01
//     -> wrap build: alu_out=0x00, z=1, p=0, c=1.
//     -> SAT build: alu_out=0xFF, c=1, p=1.
//  3. INC a=2 b=9 -> alu_out=3, p=0.
//     SUB a=2 b=9 -> wrap: alu_out=0xF9, c=1; SAT: alu_out=0x00.
//  4. Stream 6 ops back-to-back with out_ready=0 for cycles 3-6
//     -> in_ready drops once both stages are full; outputs stable during stall;
//        all 6 tags delivered in order, none duplicated.
//  5. Assert rst while 2 ops are in flight
//     -> next cycle: out_valid=0, busy=0, in_ready=1; neither op is ever delivered.
//  6. SHL a=0x81 b=0x09 (shift = 1) -> alu_out=0x02, p=1.
//     PASSB b=0 -> z=1, p=0.

Source files
------------

// File: rtl/alu_pipe_if.sv
// -----------------------------------------------------------------------------
// alu_pipe_if
//   Handshake/data bundle between the decode stage (master) and alu_pipe
//   (slave).
//   Request side  : in_valid, in_ready, a, b, alu_op, in_tag
//   Response side : out_valid, out_ready, alu_out, p_flag, z_flag, c_flag,
//                   out_tag
//   Status        : busy (either pipeline stage holds a valid entry)
// -----------------------------------------------------------------------------
interface alu_pipe_if #(
    parameter int DATAW = 16,
    parameter int TAGW  = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [DATAW-1:0] a;
    logic [DATAW-1:0] b;
    logic [2:0]       alu_op;
    logic [TAGW-1:0]  in_tag;

    logic             out_valid;
    logic             out_ready;
    logic [DATAW-1:0] alu_out;
    logic             p_flag;
    logic             z_flag;
    logic             c_flag;
    logic [TAGW-1:0]  out_tag;

    logic             busy;

    // Producer of operations / consumer of results.
    modport master (
        output in_valid, a, b, alu_op, in_tag, out_ready,
        input  in_ready, out_valid, alu_out, p_flag, z_flag, c_flag, out_tag, busy
    );

    // The ALU itself.
    modport slave (
        input  in_valid, a, b, alu_op, in_tag, out_ready,
        output in_ready, out_valid, alu_out, p_flag, z_flag, c_flag, out_tag, busy
    );
endinterface

// File: rtl/alu_pipe.sv
// -----------------------------------------------------------------------------
// alu_pipe
//   Two-stage pipelined ALU with valid/ready handshakes on both sides and a
//   pass-through tag. S1 registers the accepted operands/op/tag; S2 registers
//   the computed result, P/Z/C flags and tag, and drives the outputs.
//
//   Ports
//     clk  : clock, all state on the rising edge
//     rst  : synchronous, active-high reset (discards both stages)
//     bus  : alu_pipe_if.slave (request a/b/alu_op/in_tag with in_valid/
//            in_ready; response alu_out/flags/out_tag with out_valid/
//            out_ready; busy status)
//
//   Operations: ADD INC SUB AND OR XOR SHL PASSB (alu_op 0..7).
//
//   Configuration
//     ALU_PIPE_SAT_EN : when defined, ADD/INC clamp to all-ones on carry and
//                       SUB clamps to zero on borrow; c_flag still reports the
//                       raw carry/borrow. Undefined: wrapping arithmetic only.
// -----------------------------------------------------------------------------
module alu_pipe #(
    parameter int DATAW = 16,
    parameter int TAGW  = 4
) (
    input  logic       clk,
    input  logic       rst,
    alu_pipe_if.slave  bus
);
    localparam int SHW = $clog2(DATAW);

    typedef enum logic [2:0] {
        OP_ADD   = 3'd0,
        OP_INC   = 3'd1,
        OP_SUB   = 3'd2,
        OP_AND   = 3'd3,
        OP_OR    = 3'd4,
        OP_XOR   = 3'd5,
        OP_SHL   = 3'd6,
        OP_PASSB = 3'd7
    } op_e;

    typedef struct packed {
        logic [DATAW-1:0] a;
        logic [DATAW-1:0] b;
        op_e              op;
        logic [TAGW-1:0]  tag;
    } req_t;

    typedef struct packed {
        logic [DATAW-1:0] res;
        logic             p;
        logic             z;
        logic             c;
        logic [TAGW-1:0]  tag;
    } rsp_t;

    // vld_pipe[1] = S1 valid, vld_pipe[2] = S2 valid (== out_valid)
    logic [2:1] vld_pipe;
    req_t       s1;
    rsp_t       s2;
    rsp_t       nxt;

    logic s2_load;
    logic s1_adv;
    logic accept;

    // S2 takes a new entry when it is empty or its current one is leaving;
    // S1 moves on in the same cycle, so in_ready sees out_ready combinationally
    // and a full pipe drains without a bubble.
    assign s2_load      = !vld_pipe[2] || bus.out_ready;
    assign s1_adv       = s2_load;
    assign bus.in_ready = !vld_pipe[1] || s1_adv;
    assign accept       = bus.in_valid && bus.in_ready;

    // ------------------------------------------------------------------
    // Execute: combinational from S1, registered into S2.
    // ------------------------------------------------------------------
    logic [DATAW:0]   sum_ab;
    logic [DATAW:0]   sum_inc;
    logic [DATAW:0]   diff;
    logic             a_gt_b;
    logic             use_cmp;
    logic [DATAW-1:0] res;
    logic             cy;

    always_comb begin
        sum_ab  = {1'b0, s1.a} + {1'b0, s1.b};
        sum_inc = {1'b0, s1.a} + {{DATAW{1'b0}}, 1'b1};
        // Top bit of the widened difference is the borrow (a < b).
        diff    = {1'b0, s1.a} - {1'b0, s1.b};
        a_gt_b  = s1.a > s1.b;
        res     = '0;
        cy      = 1'b0;
        use_cmp = 1'b0;

        case (s1.op)
            OP_ADD: begin
                res = sum_ab[DATAW-1:0];
                cy  = sum_ab[DATAW];
            end
            OP_INC: begin
                res     = sum_inc[DATAW-1:0];
                cy      = sum_inc[DATAW];
                use_cmp = 1'b1;
            end
            OP_SUB: begin
                res     = diff[DATAW-1:0];
                cy      = diff[DATAW];
                use_cmp = 1'b1;
            end
            OP_AND:   res = s1.a & s1.b;
            OP_OR:    res = s1.a | s1.b;
            OP_XOR:   res = s1.a ^ s1.b;
            OP_SHL:   res = s1.a << s1.b[SHW-1:0];
            OP_PASSB: res = s1.b;
            default:  res = '0;
        endcase

`ifdef ALU_PIPE_SAT_EN
        // Clamp on overflow; cy keeps the raw carry/borrow for c_flag.
        if (cy && (s1.op == OP_ADD || s1.op == OP_INC)) begin
            res = '1;
        end else if (cy && s1.op == OP_SUB) begin
            res = '0;
        end
`else
        // Wrapping build: res already holds the modulo-2^DATAW result.
`endif

        // INC/SUB predicate is the operand compare; every other op
        // (ADD included, after any clamp) reports a non-zero result.
        nxt.res = res;
        nxt.c   = cy;
        nxt.p   = use_cmp ? a_gt_b : (res != '0);
        nxt.z   = (res == '0);
        nxt.tag = s1.tag;
    end

    // ------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            s1       <= '0;
            s2       <= '0;
        end else begin
            // S1 can fill while S2 is stalled if S1 was empty, so loading
            // is keyed on accept rather than on s1_adv alone.
            if (accept) begin
                vld_pipe[1] <= 1'b1;
                s1.a        <= bus.a;
                s1.b        <= bus.b;
                s1.op       <= op_e'(bus.alu_op);
                s1.tag      <= bus.in_tag;
            end else if (s1_adv) begin
                vld_pipe[1] <= 1'b0;
            end

            // On a stall S2 is untouched, so every output holds stable.
            if (s2_load) begin
                vld_pipe[2] <= vld_pipe[1];
                if (vld_pipe[1]) begin
                    s2 <= nxt;
                end
            end
        end
    end

    assign bus.out_valid = vld_pipe[2];
    assign bus.alu_out   = s2.res;
    assign bus.p_flag    = s2.p;
    assign bus.z_flag    = s2.z;
    assign bus.c_flag    = s2.c;
    assign bus.out_tag   = s2.tag;
    assign bus.busy      = |vld_pipe;

endmodule

// File: tb/tb_alu_pipe.sv
// -----------------------------------------------------------------------------
// tb_alu_pipe
//   Self-checking bench for alu_pipe (DATAW=8, TAGW=4). Expected responses are
//   produced by an integer reference model when an operation is accepted,
//   queued, and compared when the DUT delivers. Build with +define+ALU_PIPE_SAT_EN
//   to check the saturating variant.
// -----------------------------------------------------------------------------
module tb_alu_pipe;
    localparam int DATAW = 8;
    localparam int TAGW  = 4;

    typedef struct packed {
        logic [7:0] res;
        logic       p;
        logic       z;
        logic       c;
        logic [3:0] tag;
    } rsp_t;

    logic clk = 1'b0;
    logic rst;

    alu_pipe_if #(.DATAW(DATAW), .TAGW(TAGW)) bus ();

    alu_pipe #(.DATAW(DATAW), .TAGW(TAGW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    rsp_t sb[$];

    // Reference model, written in plain integer arithmetic.
    function automatic rsp_t model(logic [7:0] a, logic [7:0] b,
                                   logic [2:0] op, logic [3:0] tag);
        int unsigned ai, bi, r;
        bit          c, cmp;
        rsp_t        m;
        ai = a; bi = b; r = 0; c = 0; cmp = 0;
        case (op)
            3'd0: begin r = ai + bi;       c = (r > 255); end
            3'd1: begin r = ai + 1;        c = (r > 255); cmp = 1; end
            3'd2: begin r = ai + 256 - bi; c = (ai < bi); cmp = 1; end
            3'd3: r = ai & bi;
            3'd4: r = ai | bi;
            3'd5: r = ai ^ bi;
            3'd6: r = ai << (bi % 8);
            default: r = bi;
        endcase
        r = r % 256;
`ifdef ALU_PIPE_SAT_EN
        if (c && op <= 3'd1) r = 255;
        if (c && op == 3'd2) r = 0;
`endif
        m.res = r[7:0];
        m.c   = c;
        m.p   = cmp ? (ai > bi) : (r != 0);
        m.z   = (r == 0);
        m.tag = tag;
        return m;
    endfunction

    function automatic rsp_t observed();
        return {bus.alu_out, bus.p_flag, bus.z_flag, bus.c_flag, bus.out_tag};
    endfunction

    task automatic drive(bit v, logic [7:0] a, logic [7:0] b,
                         logic [2:0] op, logic [3:0] tag, bit ordy);
        bus.in_valid  = v;
        bus.a         = a;
        bus.b         = b;
        bus.alu_op    = op;
        bus.in_tag    = tag;
        bus.out_ready = ordy;
    endtask

    // One clock: called at a falling edge with inputs already driven. Records
    // both handshakes of the coming rising edge in the scoreboard and returns
    // at the next falling edge.
    task automatic step(output bit acc, output bit popped, output bit have_exp,
                        output rsp_t exp, output rsp_t obs);
        #1;
        acc      = bus.in_valid && bus.in_ready;
        popped   = 1'b0;
        have_exp = 1'b0;
        exp      = '0;
        obs      = observed();
        if (bus.out_valid && bus.out_ready) begin
            popped = 1'b1;
            if (sb.size() > 0) begin
                exp      = sb.pop_front();
                have_exp = 1'b1;
            end
        end
        if (acc) sb.push_back(model(bus.a, bus.b, bus.alu_op, bus.in_tag));
        @(negedge clk);
    endtask

    // Issue one op with out_ready high; return the delivered response and the
    // cycles from accept to delivery (-1 on timeout).
    task automatic send_one(logic [7:0] a, logic [7:0] b, logic [2:0] op,
                            logic [3:0] tag, output rsp_t got, output int lat);
        bit   acc, popped, he;
        rsp_t e, o;
        int   tacc;
        tacc = -1;
        got  = '0;
        lat  = -1;
        drive(1'b1, a, b, op, tag, 1'b1);
        for (int t = 0; t < 20; t++) begin
            step(acc, popped, he, e, o);
            if (acc) begin
                tacc = t;
                bus.in_valid = 1'b0;
            end
            if (popped) begin
                got = o;
                lat = t - tacc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 8'h11, 8'h22, 3'd0, 4'h9, 1'b1);   // must be ignored
        repeat (2) @(negedge clk);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ctl: out_valid=%b busy=%b in_ready=%b required 0 0 1",
                     bus.out_valid, bus.busy, bus.in_ready);
        end
        checks++;
        if (observed() !== '0) begin
            errors++;
            $display("FAIL reset_data: actual %h required 0", observed());
        end
        @(negedge clk);
    endtask

    task automatic test_basic();
        rsp_t got;
        int   lat;
        send_one(8'd3, 8'd4, 3'd0, 4'd5, got, lat);
        checks++;
        if (got !== {8'd7, 1'b1, 1'b0, 1'b0, 4'd5}) begin
            errors++;
            $display("FAIL add_3_4: actual %h required %h", got, {8'd7, 1'b1, 1'b0, 1'b0, 4'd5});
        end
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("FAIL latency: actual %0d required 2", lat);
        end
    endtask

    // Directed vectors with hand-derived answers.
    task automatic test_ops();
        logic [7:0] va[6]  = '{8'hFF, 8'h02, 8'h02, 8'h81, 8'h55, 8'h0F};
        logic [7:0] vb[6]  = '{8'h01, 8'h09, 8'h09, 8'h09, 8'h00, 8'h3C};
        logic [2:0] vop[6] = '{3'd0,  3'd1,  3'd2,  3'd6,  3'd7,  3'd5};
        logic [3:0] vtag[6] = '{4'h1, 4'h2,  4'h3,  4'h4,  4'h6,  4'h7};
`ifdef ALU_PIPE_SAT_EN
        rsp_t vexp[6] = '{{8'hFF, 3'b101, 4'h1}, {8'h03, 3'b000, 4'h2},
                          {8'h00, 3'b011, 4'h3}, {8'h02, 3'b100, 4'h4},
                          {8'h00, 3'b010, 4'h6}, {8'h33, 3'b100, 4'h7}};
`else
        rsp_t vexp[6] = '{{8'h00, 3'b011, 4'h1}, {8'h03, 3'b000, 4'h2},
                          {8'hF9, 3'b001, 4'h3}, {8'h02, 3'b100, 4'h4},
                          {8'h00, 3'b010, 4'h6}, {8'h33, 3'b100, 4'h7}};
`endif
        rsp_t got;
        int   lat;
        for (int i = 0; i < 6; i++) begin
            send_one(va[i], vb[i], vop[i], vtag[i], got, lat);
            checks++;
            if (got !== vexp[i]) begin
                errors++;
                $display("FAIL vector_%0d op=%0d: actual %h required %h", i, vop[i], got, vexp[i]);
            end
        end
    endtask

    // Six ops streamed, consumer stalls for cycles 3-6.
    task automatic test_back_to_back();
        bit   acc, popped, he, saw_full, prev_stall;
        rsp_t e, o, prev;
        int   sent, got;
        sent = 0; got = 0; saw_full = 0; prev_stall = 0; prev = '0;
        for (int t = 0; t < 60 && got < 6; t++) begin
            if (prev_stall) begin
                checks++;
                if (observed() !== prev || bus.out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL stall_hold: actual %h required %h", observed(), prev);
                end
            end
            drive(sent < 6, 8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)),
                  4'(sent + 8), !(t >= 3 && t <= 6));
            #1;
            checks++;
            if (bus.in_ready !== (sb.size() < 2 || bus.out_ready)) begin
                errors++;
                $display("FAIL b2b_in_ready: actual %b required %b occupancy %0d",
                         bus.in_ready, (sb.size() < 2 || bus.out_ready), sb.size());
            end
            if (!bus.in_ready) saw_full = 1;
            prev_stall = bus.out_valid && !bus.out_ready;
            prev       = observed();
            step(acc, popped, he, e, o);
            if (acc) sent++;
            if (popped) begin
                got++;
                checks++;
                if (!he || o !== e) begin
                    errors++;
                    $display("FAIL b2b_result: actual %h required %h (queued=%b)", o, e, he);
                end
            end
        end
        bus.in_valid = 1'b0;
        checks++;
        if (got != 6 || sb.size() != 0 || !saw_full) begin
            errors++;
            $display("FAIL b2b_summary: delivered %0d left %0d full_seen %b required 6 0 1",
                     got, sb.size(), saw_full);
        end
    endtask

    task automatic test_random();
        bit   acc, popped, he;
        rsp_t e, o;
        for (int t = 0; t < 300; t++) begin
            drive($urandom_range(0, 9) < 7, 8'($urandom), 8'($urandom),
                  3'($urandom_range(0, 7)), 4'($urandom), $urandom_range(0, 9) < 6);
            #1;
            checks++;
            if (bus.busy !== (sb.size() != 0) ||
                bus.in_ready !== (sb.size() < 2 || bus.out_ready)) begin
                errors++;
                $display("FAIL rand_status: busy=%b in_ready=%b occupancy %0d out_ready %b",
                         bus.busy, bus.in_ready, sb.size(), bus.out_ready);
            end
            step(acc, popped, he, e, o);
            if (popped) begin
                checks++;
                if (!he || o !== e) begin
                    errors++;
                    $display("FAIL rand_result: actual %h required %h (queued=%b)", o, e, he);
                end
            end
        end
        // Drain, then confirm nothing extra appears.
        for (int t = 0; t < 12; t++) begin
            drive(1'b0, 8'h0, 8'h0, 3'd0, 4'h0, 1'b1);
            step(acc, popped, he, e, o);
            if (popped) begin
                checks++;
                if (!he || o !== e) begin
                    errors++;
                    $display("FAIL drain_result: actual %h required %h (queued=%b)", o, e, he);
                end
            end
        end
        checks++;
        if (sb.size() != 0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_empty: left %0d out_valid %b required 0 0", sb.size(), bus.out_valid);
        end
    endtask

    task automatic test_reset_midflight();
        bit   acc, popped, he;
        rsp_t e, o;
        int   n;
        n = 0;
        for (int t = 0; t < 10 && n < 2; t++) begin
            drive(1'b1, 8'(t + 1), 8'h01, 3'd0, 4'(t + 1), 1'b0);
            step(acc, popped, he, e, o);
            if (acc) n++;
        end
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1 || n != 2) begin
            errors++;
            $display("FAIL midflight_reset: out_valid=%b busy=%b in_ready=%b loaded=%0d required 0 0 1 2",
                     bus.out_valid, bus.busy, bus.in_ready, n);
        end
        @(negedge clk);
        for (int t = 0; t < 5; t++) begin
            drive(1'b0, 8'h0, 8'h0, 3'd0, 4'h0, 1'b1);
            step(acc, popped, he, e, o);
            checks++;
            if (popped) begin
                errors++;
                $display("FAIL flushed_delivery: actual tag %h required none", o.tag);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 8'h0, 8'h0, 3'd0, 4'h0, 1'b0);
        @(negedge clk);
        test_reset();
        test_basic();
        test_ops();
        test_back_to_back();
        test_random();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

endmodule
